// File: rtl/pipe_seg_hs.sv
`default_nettype none
// ============================================================================
// Module  : pipe_seg_hs
// Brief   : Pipeline segment register with valid/ready handshake, optional
//           skid entry, flush and occupancy reporting.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_seg_hs #(
    parameter int DW         = 160,
    parameter int SKID       = 1,
    parameter int ZERO_FLUSH = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occupancy
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_BOTH  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] main_q,  main_d;
    logic [DW-1:0] skid_q,  skid_d;
    logic          in_fire;
    logic          out_fire;
    logic          held_valid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            if (ZERO_FLUSH != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        // Only reachable with a skid entry; single-entry mode
                        // cannot accept while stalled.
                        if (SKID != 0) begin
                            skid_d  = in_data;
                            state_d = ST_BOTH;
                        end
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_BOTH: begin
                    if (SKID == 0) begin
                        state_d = ST_EMPTY;
                    end else if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Output decode; ready in skid mode depends only on registered state
    always_comb begin
        held_valid = (state_q == ST_FULL) || (state_q == ST_BOTH);
        out_valid  = held_valid;
        out_data   = main_q;
        case (state_q)
            ST_FULL: occupancy = 2'd1;
            ST_BOTH: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
        if (SKID != 0) begin
            in_ready = !reset && ((state_q == ST_EMPTY) || (state_q == ST_FULL));
        end else begin
            in_ready = !reset && (!held_valid || out_ready);
        end
        in_fire  = in_valid && in_ready;
        out_fire = held_valid && out_ready;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_seg_hs.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_seg_hs
// Brief   : Self-checking bench for pipe_seg_hs, SKID=0 (index 0) and SKID=1
//           (index 1) instances side by side.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipe_seg_hs;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
    } vec_t;

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  fl;
    logic [1:0]  iv;
    logic [1:0]  ordy;
    logic [1:0]  ir;
    logic [1:0]  ov;
    logic [31:0] id  [2];
    logic [31:0] od  [2];
    logic [1:0]  occ [2];

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    pipe_seg_hs #(.DW(32), .SKID(0), .ZERO_FLUSH(1)) u_s0 (
        .clk(clk), .reset(rst[0]), .flush(fl[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .occupancy(occ[0])
    );

    pipe_seg_hs #(.DW(32), .SKID(1), .ZERO_FLUSH(1)) u_s1 (
        .clk(clk), .reset(rst[1]), .flush(fl[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .occupancy(occ[1])
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic f, input logic v,
                                input logic [31:0] d, input logic o, input logic eir,
                                input logic eov, input logic [31:0] eod, input logic [1:0] eocc);
        vec_t t;
        t.rst = r; t.fl = f; t.iv = v; t.id = d; t.ordy = o;
        t.e_ir = eir; t.e_ov = eov; t.e_od = eod; t.e_occ = eocc;
        return t;
    endfunction

    // Inputs driven on the falling edge; in_ready checked before the rising
    // edge, registered outputs checked just after it.
    task automatic run_vec(input int k, input int idx, input vec_t v);
        @(negedge clk);
        rst[k] = v.rst; fl[k] = v.fl; iv[k] = v.iv; id[k] = v.id; ordy[k] = v.ordy;
        #1;
        chk($sformatf("s%0d[%0d].in_ready", k, idx), {31'd0, ir[k]}, {31'd0, v.e_ir});
        @(posedge clk);
        #1;
        chk($sformatf("s%0d[%0d].out_valid", k, idx), {31'd0, ov[k]}, {31'd0, v.e_ov});
        chk($sformatf("s%0d[%0d].out_data", k, idx), od[k], v.e_od);
        chk($sformatf("s%0d[%0d].occupancy", k, idx), {30'd0, occ[k]}, {30'd0, v.e_occ});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 2'b11; fl = 2'b00; iv = 2'b00; ordy = 2'b00;
        id[0] = '0; id[1] = '0;
        #1;
        chk("reset.in_ready0", {31'd0, ir[0]}, 32'd0);
        chk("reset.in_ready1", {31'd0, ir[1]}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("reset.out_valid", {30'd0, ov}, 32'd0);
        chk("reset.out_data0", od[0], 32'd0);
        chk("reset.out_data1", od[1], 32'd0);
        chk("reset.occ1", {30'd0, occ[1]}, 32'd0);
        rst = 2'b00;
        #1;
        chk("post_reset.in_ready", {30'd0, ir}, 32'd3);
    endtask

    vec_t v1[$];
    vec_t v0[$];

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] ctr;
    logic [31:0] front;
    logic [1:0]  hold;
    logic [31:0] hold_d [2];
    int          qsz;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 2'b11; fl = '0; iv = '0; ordy = '0; id[0] = '0; id[1] = '0;

        //          rst fl iv  id     ordy ir ov od      occ
        v1.push_back(mk(0, 0, 1, 32'h1, 1, 1, 1, 32'h1, 2'd1));
        v1.push_back(mk(0, 0, 1, 32'h2, 1, 1, 1, 32'h2, 2'd1));
        v1.push_back(mk(0, 0, 1, 32'h3, 1, 1, 1, 32'h3, 2'd1));
        v1.push_back(mk(0, 0, 0, 32'h0, 1, 1, 0, 32'h3, 2'd0));
        v1.push_back(mk(0, 0, 1, 32'hA, 0, 1, 1, 32'hA, 2'd1));
        v1.push_back(mk(0, 0, 1, 32'hB, 0, 1, 1, 32'hA, 2'd2));
        v1.push_back(mk(0, 0, 1, 32'hD, 0, 0, 1, 32'hA, 2'd2));
        v1.push_back(mk(0, 0, 1, 32'hD, 1, 0, 1, 32'hB, 2'd1));
        v1.push_back(mk(0, 0, 0, 32'h0, 1, 1, 0, 32'hB, 2'd0));
        v1.push_back(mk(0, 0, 1, 32'hA, 0, 1, 1, 32'hA, 2'd1));
        v1.push_back(mk(0, 0, 1, 32'hB, 0, 1, 1, 32'hA, 2'd2));
        v1.push_back(mk(0, 1, 1, 32'hC, 1, 0, 0, 32'h0, 2'd0));
        v1.push_back(mk(0, 0, 1, 32'hE, 0, 1, 1, 32'hE, 2'd1));
        v1.push_back(mk(0, 1, 1, 32'hC, 0, 1, 0, 32'h0, 2'd0));
        v1.push_back(mk(0, 0, 0, 32'h0, 1, 1, 0, 32'h0, 2'd0));
        v1.push_back(mk(0, 0, 1, 32'hA, 0, 1, 1, 32'hA, 2'd1));
        v1.push_back(mk(0, 0, 1, 32'hB, 0, 1, 1, 32'hA, 2'd2));
        v1.push_back(mk(1, 0, 1, 32'h9, 1, 0, 0, 32'h0, 2'd0));
        v1.push_back(mk(0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 2'd0));

        v0.push_back(mk(0, 0, 1, 32'h5, 0, 1, 1, 32'h5, 2'd1));
        v0.push_back(mk(0, 0, 1, 32'h6, 0, 0, 1, 32'h5, 2'd1));
        v0.push_back(mk(0, 0, 1, 32'h6, 1, 1, 1, 32'h6, 2'd1));
        v0.push_back(mk(0, 0, 0, 32'h0, 0, 0, 1, 32'h6, 2'd1));
        v0.push_back(mk(0, 1, 1, 32'h7, 1, 1, 0, 32'h0, 2'd0));
        v0.push_back(mk(0, 0, 0, 32'h0, 1, 1, 0, 32'h0, 2'd0));
        v0.push_back(mk(0, 0, 1, 32'h8, 1, 1, 1, 32'h8, 2'd1));
        v0.push_back(mk(1, 0, 1, 32'h9, 1, 0, 0, 32'h0, 2'd0));
        v0.push_back(mk(0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 2'd0));

        do_reset();
        foreach (v1[i]) run_vec(1, i, v1[i]);
        foreach (v0[i]) run_vec(0, i, v0[i]);

        // Random valid/ready/flush traffic on both instances with a scoreboard
        do_reset();
        ctr  = 32'h100;
        hold = 2'b00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (hold[k]) begin
                    chk($sformatf("rnd.s%0d.stall_valid", k), {31'd0, ov[k]}, 32'd1);
                    chk($sformatf("rnd.s%0d.stall_data", k), od[k], hold_d[k]);
                end
                iv[k]   = ($urandom_range(0, 9) < 7);
                ordy[k] = ($urandom_range(0, 9) < 6);
                fl[k]   = ($urandom_range(0, 49) == 0);
                id[k]   = ctr;
                ctr     = ctr + 1;
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                qsz = (k == 0) ? q0.size() : q1.size();
                if (ov[k] && ordy[k]) begin
                    if (qsz == 0) begin
                        chk($sformatf("rnd.s%0d.spurious_out", k), od[k], 32'hDEAD_BEEF);
                    end else begin
                        front = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("rnd.s%0d.order", k), od[k], front);
                    end
                end
                if (fl[k]) begin
                    if (k == 0) q0.delete(); else q1.delete();
                end else if (iv[k] && ir[k]) begin
                    if (k == 0) q0.push_back(id[k]); else q1.push_back(id[k]);
                end
                hold[k]   = ov[k] && !ordy[k] && !fl[k];
                hold_d[k] = od[k];
            end
            @(posedge clk);
            #1;
            chk("rnd.s0.occupancy", {30'd0, occ[0]}, q0.size());
            chk("rnd.s1.occupancy", {30'd0, occ[1]}, q1.size());
            chk("rnd.s0.out_valid", {31'd0, ov[0]}, {31'd0, (q0.size() != 0)});
            chk("rnd.s1.out_valid", {31'd0, ov[1]}, {31'd0, (q1.size() != 0)});
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
